// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep (chirp) controller feeding the DDS phase_incr input.
// Steps from f_start to f_stop with a programmable dwell, in single, sawtooth or triangle mode.
module dds_sweep_ctrl #(
  parameter int PHASE_WIDTH = 4,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [1:0]             mode_i,
  input  logic [PHASE_WIDTH-1:0] f_start_i,
  input  logic [PHASE_WIDTH-1:0] f_stop_i,
  input  logic [PHASE_WIDTH-1:0] f_step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output logic [PHASE_WIDTH-1:0] phase_incr_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   wrap_o,
  output logic                   cfg_err_o
);

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic {ST_IDLE, ST_DWELL} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  typedef struct packed {
    logic [1:0]             mode;
    logic [PHASE_WIDTH-1:0] f_start;
    logic [PHASE_WIDTH-1:0] f_stop;
    logic [PHASE_WIDTH-1:0] f_step;
    logic [DWELL_WIDTH-1:0] dwell;
  } cfg_t;

  state_e                 state_q, state_d;
  dir_e                   dir_q, dir_d;
  cfg_t                   cfg_q, cfg_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wrap_q, wrap_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   cfg_ok;
  logic [PHASE_WIDTH:0]   sum_up;
  logic [PHASE_WIDTH:0]   diff_dn;
  logic [PHASE_WIDTH-1:0] up_next;
  logic [PHASE_WIDTH-1:0] dn_next;

  assign cfg_ok = (f_step_i != '0) && (f_start_i <= f_stop_i);

  // One extra bit on both legs: a carry-out or borrow means the step overshot and clamps.
  assign sum_up  = {1'b0, phase_q} + {1'b0, cfg_q.f_step};
  assign diff_dn = {1'b0, phase_q} - {1'b0, cfg_q.f_step};
  assign up_next = (sum_up > {1'b0, cfg_q.f_stop}) ? cfg_q.f_stop : sum_up[PHASE_WIDTH-1:0];
  assign dn_next = (diff_dn[PHASE_WIDTH] || (diff_dn[PHASE_WIDTH-1:0] < cfg_q.f_start))
                   ? cfg_q.f_start : diff_dn[PHASE_WIDTH-1:0];

  // NOTE: every signal gets a default at the top of always_comb; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    cfg_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (stop_i) begin
          phase_d = '0;
        end else if (start_i) begin
          if (cfg_ok) begin
            cfg_d.mode    = (mode_i == 2'd3) ? MODE_SINGLE : mode_i;
            cfg_d.f_start = f_start_i;
            cfg_d.f_stop  = f_stop_i;
            cfg_d.f_step  = f_step_i;
            cfg_d.dwell   = dwell_i;
            phase_d       = f_start_i;
            cnt_d         = dwell_i;
            dir_d         = DIR_UP;
            busy_d        = 1'b1;
            state_d       = ST_DWELL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_DWELL: begin
        if (stop_i) begin
          phase_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else begin
          cnt_d = cfg_q.dwell;
          if (dir_q == DIR_UP) begin
            if (phase_q != cfg_q.f_stop) begin
              phase_d = up_next;
            end else begin
              case (cfg_q.mode)
                MODE_REPEAT: begin
                  phase_d = cfg_q.f_start;
                  wrap_d  = 1'b1;
                end
                MODE_TRIANGLE: begin
                  // A degenerate range has nowhere to turn around; just restart the pass.
                  if (cfg_q.f_start == cfg_q.f_stop) begin
                    phase_d = cfg_q.f_start;
                    wrap_d  = 1'b1;
                  end else begin
                    dir_d   = DIR_DOWN;
                    phase_d = dn_next;
                    wrap_d  = (dn_next == cfg_q.f_start);
                  end
                end
                default: begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                end
              endcase
            end
          end else begin
            if (phase_q != cfg_q.f_start) begin
              phase_d = dn_next;
              wrap_d  = (dn_next == cfg_q.f_start);
            end else begin
              dir_d   = DIR_UP;
              phase_d = up_next;
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      cfg_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign phase_incr_o = phase_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign wrap_o       = wrap_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: each step queues the expected post-edge outputs,
// a checker pops and compares them shortly after every rising edge.
module tb_dds_sweep_ctrl;

  localparam int PW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, stop_i;
  logic [1:0]    mode_i;
  logic [PW-1:0] f_start_i, f_stop_i, f_step_i;
  logic [DW-1:0] dwell_i;
  logic [PW-1:0] phase_incr_o;
  logic          busy_o, done_o, wrap_o, cfg_err_o;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [7:0]  exp_q[$];

  dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .mode_i       (mode_i),
    .f_start_i    (f_start_i),
    .f_stop_i     (f_stop_i),
    .f_step_i     (f_step_i),
    .dwell_i      (dwell_i),
    .phase_incr_o (phase_incr_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wrap_o       (wrap_o),
    .cfg_err_o    (cfg_err_o)
  );

  always #5 clk = ~clk;

  // Values packed as {phase, busy, done, wrap, cfg_err}.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $error("FAIL %s: got ph=%0d b=%b d=%b w=%b e=%b, want ph=%0d b=%b d=%b w=%b e=%b",
             tag, got[7:4], got[3], got[2], got[1], got[0],
             want[7:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  function automatic logic [7:0] outs();
    return {phase_incr_o, busy_o, done_o, wrap_o, cfg_err_o};
  endfunction

  // Sampled 2 time units after the edge.
  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      string      t;
      logic [7:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, outs(), e);
    end
  end

  task automatic tick(input string tag, input int ph, input logic b, input logic d,
                      input logic w, input logic e);
    tag_q.push_back(tag);
    exp_q.push_back({ph[PW-1:0], b, d, w, e});
    @(posedge clk);
    #3;
  endtask

  task automatic set_cfg(input logic [1:0] m, input int fs, input int fe, input int st,
                         input int dw);
    mode_i    = m;
    f_start_i = fs[PW-1:0];
    f_stop_i  = fe[PW-1:0];
    f_step_i  = st[PW-1:0];
    dwell_i   = dw[DW-1:0];
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    set_cfg(2'd0, 0, 0, 0, 0);
    tick("reset0", 0, 0, 0, 0, 0);
    tick("reset1", 0, 0, 0, 0, 0);
    check("reset_state", outs(), 8'h00);
    rst = 1'b0;
    tick("idle", 0, 0, 0, 0, 0);

    // Single up sweep 2..8 step 3, dwell 2; mid-sweep input changes must be ignored.
    set_cfg(2'd0, 2, 8, 3, 2);
    start_i = 1'b1;
    tick("m0_load", 2, 1, 0, 0, 0);
    start_i = 1'b0;
    set_cfg(2'd1, 1, 4, 1, 0);
    tick("m0_2b", 2, 1, 0, 0, 0);
    tick("m0_2c", 2, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("m0_5", 5, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("m0_8", 8, 1, 0, 0, 0);
    tick("m0_done", 8, 0, 1, 0, 0);
    check("m0_done_direct", outs(), {4'd8, 1'b0, 1'b1, 1'b0, 1'b0});
    tick("m0_hold", 8, 0, 0, 0, 0);

    // Rejected configurations: phase and busy unchanged.
    set_cfg(2'd0, 2, 8, 0, 0);
    start_i = 1'b1;
    tick("err_step0", 8, 0, 0, 0, 1);
    start_i = 1'b0;
    tick("err_step0_clr", 8, 0, 0, 0, 0);
    set_cfg(2'd0, 9, 4, 3, 0);
    start_i = 1'b1;
    tick("err_order", 8, 0, 0, 0, 1);
    start_i = 1'b0;
    tick("err_order_clr", 8, 0, 0, 0, 0);

    stop_i = 1'b1;
    tick("idle_stop", 0, 0, 0, 0, 0);
    stop_i = 1'b0;

    // Triangle 2..8 step 3, dwell 0.
    set_cfg(2'd2, 2, 8, 3, 0);
    start_i = 1'b1;
    tick("tri_load", 2, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("tri_5u", 5, 1, 0, 0, 0);
    tick("tri_8", 8, 1, 0, 0, 0);
    tick("tri_5d", 5, 1, 0, 0, 0);
    tick("tri_2w", 2, 1, 0, 1, 0);
    set_cfg(2'd0, 0, 0, 0, 0);
    start_i = 1'b1;
    tick("tri_busy_start", 5, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("tri_8b", 8, 1, 0, 0, 0);
    tick("tri_5db", 5, 1, 0, 0, 0);
    rst = 1'b1;
    tick("tri_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    set_cfg(2'd2, 2, 8, 3, 0);
    start_i = 1'b1;
    tick("tri_restart", 2, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("tri_restart_up", 5, 1, 0, 0, 0);
    tick("tri_restart_8", 8, 1, 0, 0, 0);
    stop_i = 1'b1;
    tick("tri_stop", 0, 0, 0, 0, 0);
    stop_i = 1'b0;

    // Overflow clamp: 10 -> 14 -> 15 (14+4 carries out).
    set_cfg(2'd0, 10, 15, 4, 0);
    start_i = 1'b1;
    tick("ovf_load", 10, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("ovf_14", 14, 1, 0, 0, 0);
    tick("ovf_15", 15, 1, 0, 0, 0);
    tick("ovf_done", 15, 0, 1, 0, 0);
    tick("ovf_hold", 15, 0, 0, 0, 0);

    // Sawtooth 2..8 step 3, dwell 1, stopped on second cycle of 5 in the second pass.
    set_cfg(2'd1, 2, 8, 3, 1);
    start_i = 1'b1;
    tick("saw_load", 2, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("saw_2", 2, 1, 0, 0, 0);
    tick("saw_5a", 5, 1, 0, 0, 0);
    tick("saw_5b", 5, 1, 0, 0, 0);
    tick("saw_8a", 8, 1, 0, 0, 0);
    tick("saw_8b", 8, 1, 0, 0, 0);
    tick("saw_wrap", 2, 1, 0, 1, 0);
    tick("saw_2b", 2, 1, 0, 0, 0);
    tick("saw_5c", 5, 1, 0, 0, 0);
    tick("saw_5d", 5, 1, 0, 0, 0);
    stop_i = 1'b1;
    tick("saw_stop", 0, 0, 0, 0, 0);
    start_i = 1'b1;
    tick("start_and_stop", 0, 0, 0, 0, 0);
    start_i = 1'b0; stop_i = 1'b0;
    tick("post_stop_idle", 0, 0, 0, 0, 0);

    // Degenerate range f_start == f_stop.
    set_cfg(2'd1, 5, 5, 1, 1);
    start_i = 1'b1;
    tick("eq_saw_load", 5, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("eq_saw_hold", 5, 1, 0, 0, 0);
    tick("eq_saw_wrap", 5, 1, 0, 1, 0);
    tick("eq_saw_hold2", 5, 1, 0, 0, 0);
    tick("eq_saw_wrap2", 5, 1, 0, 1, 0);
    stop_i = 1'b1;
    tick("eq_saw_stop", 0, 0, 0, 0, 0);
    stop_i = 1'b0;
    set_cfg(2'd2, 6, 6, 2, 0);
    start_i = 1'b1;
    tick("eq_tri_load", 6, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("eq_tri_wrap", 6, 1, 0, 1, 0);
    tick("eq_tri_wrap2", 6, 1, 0, 1, 0);
    stop_i = 1'b1;
    tick("eq_tri_stop", 0, 0, 0, 0, 0);
    stop_i = 1'b0;
    set_cfg(2'd3, 5, 5, 1, 1);
    start_i = 1'b1;
    tick("eq_m3_load", 5, 1, 0, 0, 0);
    start_i = 1'b0;
    tick("eq_m3_hold", 5, 1, 0, 0, 0);
    tick("eq_m3_done", 5, 0, 1, 0, 0);
    tick("eq_m3_idle", 5, 0, 0, 0, 0);

    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep (chirp) controller sitting directly upstream of the DDS core. It drives the DDS phase_incr input with a stepped sequence from f_start to f_stop, holding each value for a programmable dwell time. It supports single, sawtooth-repeat and triangle sweeps, with busy/done/wrap status for the test harness.

Parameters:
phase_width, 4, width of frequency words; matches the DDS phase_incr width
dwell_width, 16, width of the dwell counter

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
stop  in  1  abort the sweep; highest priority
mode  in  2  0 = single up, 1 = repeat up (sawtooth), 2 = triangle, 3 = treated as 0
f_start  in  phase_width  first/lowest frequency word
f_stop  in  phase_width  last/highest frequency word
f_step  in  phase_width  increment per step
dwell  in  dwell_width  hold count; each value is held dwell+1 cycles
phase_incr  out  phase_width  frequency word to the DDS (registered)
busy  out  1  high while sweeping
done  out  1  one-cycle pulse at the natural end of a mode-0 sweep
wrap  out  1  one-cycle pulse at each restart of a pass in modes 1/2
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: phase_incr=0, busy=0, done=0, wrap=0, cfg_err=0, state=IDLE, dir=up, counter=0.
- All outputs are registered. Config (mode, f_start, f_stop, f_step, dwell) is latched on an accepted start. Input changes mid-sweep are ignored.
- States: IDLE, DWELL.
- IDLE:
  - phase_incr holds its last value.
  - On start with a valid config: next cycle phase_incr=f_start, busy=1, counter=dwell, dir=up, go to DWELL. Latency is 1 cycle.
  - A config is invalid if f_step==0 or f_start>f_stop. An invalid start pulses cfg_err for 1 cycle; state, phase_incr and busy are unchanged.
- DWELL:
  - counter decrements by 1 each cycle. When counter==0, the next value is loaded and counter reloads to dwell.
  - Up leg:
    - If cur<f_stop, next = min(cur+f_step, f_stop). The sum is computed in phase_width+1 bits, so carry-out counts as exceeding f_stop.
    - If cur==f_stop, the next value depends on mode:
    - mode 0: go to IDLE, busy=0, done=1 for 1 cycle; phase_incr stays f_stop.
    - mode 1: next=f_start, wrap=1 in the same cycle phase_incr becomes f_start.
    - mode 2: dir=down, next=max(cur-f_step, f_start). The subtraction underflow clamps to f_start.
  - Down leg (mode 2):
    - If cur>f_start, next = max(cur-f_step, f_start). wrap=1 in the cycle phase_incr becomes f_start.
    - If cur==f_start, dir=up and next = min(cur+f_step, f_stop).
  - f_start==f_stop: mode 0 holds dwell+1 cycles, then done. Modes 1 and 2 reload f_start every dwell period with a wrap pulse each time; no direction change occurs.
- stop:
  - In DWELL: next cycle state=IDLE, phase_incr=0, busy=0. No done or wrap pulse is generated.
  - stop wins over simultaneous start, step or end-of-sweep.
  - In IDLE, stop forces phase_incr=0.
- start while busy is ignored; no cfg_err is raised.
- rst mid-sweep: next cycle all outputs take their reset values.
- done, wrap and cfg_err are never high simultaneously.

Test Plan:
- mode0, f_start=2, f_stop=8, f_step=3, dwell=2, start at cycle N:
  - phase_incr=2 for N+1..N+3, 5 for N+4..N+6, 8 for N+7..N+9.
  - busy=0 and done=1 at N+10 only; phase_incr stays 8.
- mode2, 2/8/3, dwell=0: phase_incr sequence 2,5,8,5,2,5,8,5,2… one value per cycle; wrap high exactly on each return to 2 (not on the initial load).
- phase_width=4, mode0, f_start=10, f_stop=15, f_step=4, dwell=0: sequence 10,14,15 then done. The overflow clamps; no wrap to a small value occurs.
- mode1, 2/8/3, dwell=1, stop asserted on the 2nd cycle of value 5:
  - Before stop: 2,2,5,5,8,8,2(wrap),2,5…
  - After stop: next cycle phase_incr=0, busy=0, no done.
  - start and stop asserted together: remain IDLE.
- Invalid configs:
  - start with f_step=0 -> cfg_err 1 cycle, busy stays 0.
  - start with f_start=9, f_stop=4 -> same.
  - start during an active sweep -> ignored, no cfg_err.
- rst asserted mid-DWELL in mode2 -> next cycle phase_incr=0, busy=0, all pulses 0. A fresh start afterwards begins from f_start with dir=up.
